scroll_addr_gen: RTL and testbench

- Next-generation wrap-around framebuffer address generator for scrolling backgrounds.
- Converts pixel counters into a linear ROM/BRAM address with 2-D wrap.
- Scroll offsets are latched once per frame and reduced by a small FSM, so no divider or modulo hardware is needed.
- Adds a registered 2-stage pipeline with valid tracking, and a frame-driven auto-scroll mode. Sits between the VGA counter logic and the background image memory.

---
 rtl/scroll_addr_gen_if.sv | 44 ++++
 rtl/scroll_addr_gen.sv | 177 +++++++++++++++++
 tb/tb_scroll_addr_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_addr_gen_if.sv
// Bundles the scroll generator's control, pixel and status signals.
// The mirror_x pin exists only when SCROLL_ADDR_MIRROR_EN is defined.
interface scroll_addr_gen_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 10,
  parameter int POS_W  = 11,
  parameter int STEP_W = 4
);
  logic              frame_start;
  logic              mode;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic [STEP_W-1:0] step_x;
  logic              dir;
  logic              in_valid;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
`ifdef SCROLL_ADDR_MIRROR_EN
  logic              mirror_x;
`endif
  logic              out_valid;
  logic [ADDR_W-1:0] pixel_addr;
  logic              oob;
  logic              busy;
  logic              frame_drop;
  logic [POS_W-1:0]  cur_x;
  logic [POS_W-1:0]  cur_y;

  modport master (
`ifdef SCROLL_ADDR_MIRROR_EN
    output mirror_x,
`endif
    output frame_start, mode, pos_x, pos_y, step_x, dir, in_valid, h_cnt, v_cnt,
    input  out_valid, pixel_addr, oob, busy, frame_drop, cur_x, cur_y
  );

  modport slave (
`ifdef SCROLL_ADDR_MIRROR_EN
    input  mirror_x,
`endif
    input  frame_start, mode, pos_x, pos_y, step_x, dir, in_valid, h_cnt, v_cnt,
    output out_valid, pixel_addr, oob, busy, frame_drop, cur_x, cur_y
  );
endinterface

// File: rtl/scroll_addr_gen.sv
// Wrap-around framebuffer address generator: per-frame offset reduction FSM plus a
// 2-stage pixel address pipeline. Optional horizontal mirror via SCROLL_ADDR_MIRROR_EN.
module scroll_addr_gen #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 10,
  parameter int POS_W  = 11,
  parameter int STEP_W = 4
) (
  input logic clk,
  input logic rst,
  scroll_addr_gen_if.slave bus
);
  localparam int PW = POS_W + 1;
  localparam logic [PW-1:0]     W_P = PW'(IMG_W);
  localparam logic [PW-1:0]     H_P = PW'(IMG_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {IDLE, REDUCE, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pend_x_q, pend_x_d;
  logic [PW-1:0]    pend_y_q, pend_y_d;
  logic [POS_W-1:0] cur_x_q, cur_x_d;
  logic [POS_W-1:0] cur_y_q, cur_y_d;
  logic             frame_drop_q, frame_drop_d;
  logic             busy;
`ifdef SCROLL_ADDR_MIRROR_EN
  logic             pend_mirror_q, pend_mirror_d;
  logic             mirror_q, mirror_d;
`endif

  logic [PW-1:0]     h_ext, v_ext, x_diff, y_diff, x_rel, y_rel;
  logic              oob1;
  logic              s1_valid_q, s1_oob_q;
  logic [PW-1:0]     s1_x_q, s1_y_q;
  logic              out_valid_q, oob_q;
  logic [ADDR_W-1:0] pixel_addr_q, addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      frame_drop_q <= 1'b0;
`ifdef SCROLL_ADDR_MIRROR_EN
      pend_mirror_q <= 1'b0;
      mirror_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      frame_drop_q <= frame_drop_d;
`ifdef SCROLL_ADDR_MIRROR_EN
      pend_mirror_q <= pend_mirror_d;
      mirror_q      <= mirror_d;
`endif
    end
  end

  // Repeated subtraction replaces a modulo; one cycle is spent confirming both are in range.
  always_comb begin
    state_d      = state_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    frame_drop_d = 1'b0;
`ifdef SCROLL_ADDR_MIRROR_EN
    pend_mirror_d = pend_mirror_q;
    mirror_d      = mirror_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          pend_y_d = PW'(bus.pos_y);
          if (bus.mode) begin
            pend_x_d = bus.dir ? PW'(cur_x_q) + W_P - PW'(bus.step_x)
                               : PW'(cur_x_q) + PW'(bus.step_x);
          end else begin
            pend_x_d = PW'(bus.pos_x);
          end
`ifdef SCROLL_ADDR_MIRROR_EN
          pend_mirror_d = bus.mirror_x;
`endif
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        frame_drop_d = bus.frame_start;
        if (pend_x_q < W_P && pend_y_q < H_P) begin
          state_d = COMMIT;
        end else begin
          if (pend_x_q >= W_P) pend_x_d = pend_x_q - W_P;
          if (pend_y_q >= H_P) pend_y_d = pend_y_q - H_P;
        end
      end
      COMMIT: begin
        frame_drop_d = bus.frame_start;
        cur_x_d      = POS_W'(pend_x_q);
        cur_y_d      = POS_W'(pend_y_q);
`ifdef SCROLL_ADDR_MIRROR_EN
        mirror_d     = pend_mirror_q;
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Stage 1 arithmetic; a negative difference shows up in the extra top bit.
  always_comb begin
    h_ext  = PW'(bus.h_cnt);
    v_ext  = PW'(bus.v_cnt);
    x_diff = h_ext - PW'(cur_x_q);
    y_diff = v_ext - PW'(cur_y_q);
    x_rel  = x_diff[PW-1] ? x_diff + W_P : x_diff;
    y_rel  = y_diff[PW-1] ? y_diff + H_P : y_diff;
`ifdef SCROLL_ADDR_MIRROR_EN
    if (mirror_q) x_rel = W_P - PW'(1) - x_rel;
`endif
    oob1   = (h_ext >= W_P) | (v_ext >= H_P);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_oob_q <= oob1;
        s1_x_q   <= x_rel;
        s1_y_q   <= y_rel;
      end
    end
  end

  always_comb begin
    addr_d = s1_oob_q ? '0 : ADDR_W'(s1_y_q) * W_A + ADDR_W'(s1_x_q);
  end

  // Address and oob hold their last values whenever no valid pixel arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      pixel_addr_q <= '0;
      oob_q        <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        pixel_addr_q <= addr_d;
        oob_q        <= s1_oob_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.pixel_addr = pixel_addr_q;
  assign bus.oob        = oob_q;
  assign bus.busy       = busy;
  assign bus.frame_drop = frame_drop_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
endmodule

// File: tb/tb_scroll_addr_gen.sv
// Self-checking bench for scroll_addr_gen: vector table, hand-written corner sequences,
// and a randomized pixel stream compared against a modulo-arithmetic reference model.
module tb_scroll_addr_gen;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 10;
  localparam int POS_W  = 11;
  localparam int STEP_W = 4;

  logic clk = 1'b0;
  logic rst;

  scroll_addr_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .POS_W(POS_W), .STEP_W(STEP_W)) bus ();

  scroll_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .CNT_W(CNT_W), .POS_W(POS_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int mcx = 0;
  int mcy = 0;

  typedef struct {
    int px, py, h, v, busy, curX, curY, addr, oob;
  } vec_t;
  vec_t vecs[10];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int valid, input int h, input int v);
    bus.in_valid = 1'(valid);
    bus.h_cnt    = CNT_W'(h);
    bus.v_cnt    = CNT_W'(v);
  endtask

  function automatic int refOob(input int h, input int v);
    return (h >= IMG_W || v >= IMG_H) ? 1 : 0;
  endfunction

  function automatic int refAddr(input int h, input int v);
    if (refOob(h, v) != 0) return 0;
    return ((v - mcy + IMG_H) % IMG_H) * IMG_W + ((h - mcx + IMG_W) % IMG_W);
  endfunction

  // Issue one frame update, wait for it (bounded), and check against the model.
  task automatic frameAndCheck(input string name, input int m, input int px, input int py,
                               input int step, input int d, output int busyCycles);
    int pendX, expBusy;
    pendX   = (m != 0) ? ((d != 0) ? mcx + IMG_W - step : mcx + step) : px;
    expBusy = ((pendX / IMG_W > py / IMG_H) ? pendX / IMG_W : py / IMG_H) + 2;
    bus.frame_start = 1'b1;
    bus.mode        = 1'(m);
    bus.pos_x       = POS_W'(px);
    bus.pos_y       = POS_W'(py);
    bus.step_x      = STEP_W'(step);
    bus.dir         = 1'(d);
    tick();
    bus.frame_start = 1'b0;
    busyCycles = 0;
    while (bus.busy && busyCycles < 100) begin
      busyCycles++;
      tick();
    end
    mcx = pendX % IMG_W;
    mcy = py % IMG_H;
    checkOutput({name, " busy"}, busyCycles, expBusy);
    checkOutput({name, " cur_x"}, bus.cur_x, mcx);
    checkOutput({name, " cur_y"}, bus.cur_y, mcy);
  endtask

  task automatic lookupPixel(input string name, input int h, input int v,
                             input int expAddr, input int expOob);
    applyStimulus(1, h, v);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput({name, " early valid"}, bus.out_valid, 0);
    tick();
    checkOutput({name, " out_valid"}, bus.out_valid, 1);
    checkOutput({name, " addr"}, bus.pixel_addr, expAddr);
    checkOutput({name, " oob"}, bus.oob, expOob);
  endtask

  task automatic streamRandom(input int n);
    int qv[$], qa[$], qo[$];
    int ev, ea, eo, lastA, lastO, vld, h, v;
    bit hasLast;
    hasLast = 0;
    lastA = 0;
    lastO = 0;
    for (int c = 0; c < n + 2; c++) begin
      vld = (c < n) ? int'($urandom_range(0, 1)) : 0;
      h   = int'($urandom_range(0, 399));
      v   = int'($urandom_range(0, 259));
      applyStimulus(vld, h, v);
      qv.push_back(vld);
      qa.push_back(refAddr(h, v));
      qo.push_back(refOob(h, v));
      tick();
      if (qv.size() == 2) begin
        ev = qv.pop_front();
        ea = qa.pop_front();
        eo = qo.pop_front();
        checkOutput("stream out_valid", bus.out_valid, ev);
        if (ev != 0) begin
          lastA = ea;
          lastO = eo;
          hasLast = 1;
        end
        if (hasLast) begin
          checkOutput("stream addr", bus.pixel_addr, lastA);
          checkOutput("stream oob", bus.oob, lastO);
        end
      end
    end
  endtask

  initial begin
    int bc;
    vecs[0] = '{0,    0,    5,   2,   2,  0,   0,   645,   0};
    vecs[1] = '{10,   0,    3,   0,   2,  10,  0,   313,   0};
    vecs[2] = '{0,    5,    0,   1,   2,  0,   5,   75520, 0};
    vecs[3] = '{1000, 500,  40,  20,  5,  40,  20,  0,     0};
    vecs[4] = '{319,  239,  0,   0,   2,  319, 239, 321,   0};
    vecs[5] = '{2047, 2047, 127, 127, 10, 127, 127, 0,     0};
    vecs[6] = '{2047, 2047, 400, 0,   10, 127, 127, 0,     1};
    vecs[7] = '{0,    0,    319, 239, 2,  0,   0,   76799, 0};
    vecs[8] = '{0,    0,    0,   300, 2,  0,   0,   0,     1};
    vecs[9] = '{5,    7,    4,   6,   2,  5,   7,   76799, 0};

    rst = 1'b0;
    bus.frame_start = 1'b0;
    bus.mode = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    bus.step_x = '0;
    bus.dir = 1'b0;
`ifdef SCROLL_ADDR_MIRROR_EN
    bus.mirror_x = 1'b0;
`endif
    applyStimulus(0, 0, 0);
    #12;
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset pixel_addr", bus.pixel_addr, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset frame_drop", bus.frame_drop, 0);
    checkOutput("reset cur_x", bus.cur_x, 0);
    checkOutput("reset cur_y", bus.cur_y, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      frameAndCheck($sformatf("vec%0d", i), 0, vecs[i].px, vecs[i].py, 0, 0, bc);
      checkOutput($sformatf("vec%0d table busy", i), bc, vecs[i].busy);
      checkOutput($sformatf("vec%0d table cur_x", i), bus.cur_x, vecs[i].curX);
      checkOutput($sformatf("vec%0d table cur_y", i), bus.cur_y, vecs[i].curY);
      lookupPixel($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].addr, vecs[i].oob);
    end

    frameAndCheck("auto pre", 0, 315, 0, 0, 0, bc);
    frameAndCheck("auto +7 wrap", 1, 0, 0, 7, 0, bc);
    checkOutput("auto +7 wrap const", bus.cur_x, 2);
    checkOutput("auto +7 wrap busy const", bc, 3);
    frameAndCheck("auto pre2", 0, 3, 0, 0, 0, bc);
    frameAndCheck("auto -7 wrap", 1, 0, 0, 7, 1, bc);
    checkOutput("auto -7 wrap const", bus.cur_x, 316);
    frameAndCheck("auto pre3", 0, 0, 0, 0, 0, bc);
    for (int f = 0; f < 5; f++) frameAndCheck($sformatf("auto frame%0d", f), 1, 0, 250, 7, 0, bc);
    checkOutput("auto 5 frames cur_x", bus.cur_x, 35);
    checkOutput("auto 5 frames cur_y", bus.cur_y, 10);

    bus.frame_start = 1'b1;
    bus.mode = 1'b0;
    bus.pos_x = POS_W'(1000);
    bus.pos_y = POS_W'(500);
    tick();
    bus.pos_x = POS_W'(7);
    bus.pos_y = POS_W'(7);
    tick();
    bus.frame_start = 1'b0;
    checkOutput("collision frame_drop pulse", bus.frame_drop, 1);
    tick();
    checkOutput("collision frame_drop end", bus.frame_drop, 0);
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      tick();
    end
    checkOutput("collision busy done", bus.busy, 0);
    checkOutput("collision cur_x", bus.cur_x, 40);
    checkOutput("collision cur_y", bus.cur_y, 20);
    mcx = 40;
    mcy = 20;
    lookupPixel("collision oob", 400, 0, 0, 1);

    bus.frame_start = 1'b1;
    bus.pos_x = POS_W'(100);
    bus.pos_y = POS_W'(0);
    tick();
    bus.frame_start = 1'b0;
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(1, 0, 0);
    checkOutput("switch reduce-cycle pixel", bus.pixel_addr, 70680);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("switch commit-cycle pixel", bus.pixel_addr, 70680);
    tick();
    checkOutput("switch post-commit pixel", bus.pixel_addr, 220);
    checkOutput("switch post-commit valid", bus.out_valid, 1);
    mcx = 100;
    mcy = 0;

`ifdef SCROLL_ADDR_MIRROR_EN
    bus.mirror_x = 1'b1;
    frameAndCheck("mirror on", 0, 0, 0, 0, 0, bc);
    lookupPixel("mirror h0", 0, 0, 319, 0);
    lookupPixel("mirror h319", 319, 1, 320, 0);
    bus.mirror_x = 1'b0;
    frameAndCheck("mirror off", 0, 0, 0, 0, 0, bc);
    lookupPixel("mirror off h0", 0, 0, 0, 0);
`endif

    for (int r = 0; r < 20; r++) begin
      frameAndCheck($sformatf("rnd frame%0d", r), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), bc);
      streamRandom(40);
    end

    frameAndCheck("pre-reset offsets", 0, 77, 33, 0, 0, bc);
    applyStimulus(1, 10, 10);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", bus.out_valid, 0);
    checkOutput("midreset pixel_addr", bus.pixel_addr, 0);
    checkOutput("midreset cur_x", bus.cur_x, 0);
    checkOutput("midreset cur_y", bus.cur_y, 0);
    checkOutput("midreset busy", bus.busy, 0);
    mcx = 0;
    mcy = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("release first edge out_valid", bus.out_valid, 0);
    applyStimulus(1, 5, 2);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("release pix1 valid", bus.out_valid, 1);
    checkOutput("release pix1 addr", bus.pixel_addr, 3210);
    tick();
    checkOutput("release pix2 addr", bus.pixel_addr, 645);
    tick();
    checkOutput("release idle valid", bus.out_valid, 0);
    checkOutput("release hold addr", bus.pixel_addr, 645);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
